// File: rtl/mult_issue_ctrl.sv
// ============================================================================
//  Module   : mult_issue_ctrl
//  Purpose  : Issue/retire controller in front of the signed radix-8 Booth
//             multiplier; adds the unsigned high-word fix-up for MULHU/MULHSU.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_issue_ctrl #(
    parameter int LENGTH   = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [LENGTH-1:0] req_rs1,
    input  logic [LENGTH-1:0] req_rs2,
    input  logic [4:0]        req_rd,
    input  logic              flush,
    output logic [LENGTH-1:0] oper_a,
    output logic [LENGTH-1:0] oper_b,
    output logic              enable_mult,
    output logic              operation,
    input  logic [LENGTH-1:0] mult_o,
    input  logic              mult_finish,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [LENGTH-1:0] res_data,
    output logic [4:0]        res_rd,
    output logic              res_err
);

    localparam int c_CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_MAX = c_CNT_W'(WAIT_MAX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CORR  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state_q,       w_state_d;
    logic [LENGTH-1:0]   r_a_q,           w_a_d;
    logic [LENGTH-1:0]   r_b_q,           w_b_d;
    logic [2:0]          r_funct3_q,      w_funct3_d;
    logic [4:0]          r_rd_q,          w_rd_d;
    logic [c_CNT_W-1:0]  r_cnt_q,         w_cnt_d;
    logic [LENGTH-1:0]   r_hi_q,          w_hi_d;
    logic [LENGTH-1:0]   r_oper_a_q,      w_oper_a_d;
    logic [LENGTH-1:0]   r_oper_b_q,      w_oper_b_d;
    logic                r_enable_mult_q, w_enable_mult_d;
    logic                r_operation_q,   w_operation_d;
    logic                r_req_ready_q,   w_req_ready_d;
    logic                r_res_valid_q,   w_res_valid_d;
    logic [LENGTH-1:0]   r_res_data_q,    w_res_data_d;
    logic [4:0]          r_res_rd_q,      w_res_rd_d;
    logic                r_res_err_q,     w_res_err_d;

    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic [LENGTH-1:0]   w_corr_a;
    logic [LENGTH-1:0]   w_corr_b;

    assign w_cnt_inc = r_cnt_q + c_CNT_W'(1);

    // Booth array treats both operands as signed; an operand with its MSB set
    // but meant as unsigned loses 2^LENGTH * other_operand from the product.
    assign w_corr_a = (r_funct3_q == 3'b011 && r_a_q[LENGTH-1]) ? r_b_q : '0;
    assign w_corr_b = r_b_q[LENGTH-1] ? r_a_q : '0;

    always_comb begin
        w_state_d       = r_state_q;
        w_a_d           = r_a_q;
        w_b_d           = r_b_q;
        w_funct3_d      = r_funct3_q;
        w_rd_d          = r_rd_q;
        w_cnt_d         = r_cnt_q;
        w_hi_d          = r_hi_q;
        w_oper_a_d      = r_oper_a_q;
        w_oper_b_d      = r_oper_b_q;
        w_enable_mult_d = r_enable_mult_q;
        w_operation_d   = r_operation_q;
        w_req_ready_d   = r_req_ready_q;
        w_res_valid_d   = r_res_valid_q;
        w_res_data_d    = r_res_data_q;
        w_res_rd_d      = r_res_rd_q;
        w_res_err_d     = r_res_err_q;

        if (flush) begin
            w_state_d       = S_IDLE;
            w_enable_mult_d = 1'b0;
            w_res_valid_d   = 1'b0;
            w_req_ready_d   = 1'b1;
        end else begin
            unique case (r_state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        w_a_d         = req_rs1;
                        w_b_d         = req_rs2;
                        w_funct3_d    = req_funct3;
                        w_rd_d        = req_rd;
                        w_req_ready_d = 1'b0;
                        if (req_funct3[2]) begin
                            w_state_d     = S_DONE;
                            w_res_valid_d = 1'b1;
                            w_res_err_d   = 1'b1;
                            w_res_data_d  = '0;
                            w_res_rd_d    = req_rd;
                        end else begin
                            // Outputs are registered, so the ISSUE-cycle drive
                            // is loaded on the accepting edge.
                            w_state_d       = S_ISSUE;
                            w_oper_a_d      = req_rs1;
                            w_oper_b_d      = req_rs2;
                            w_operation_d   = (req_funct3 != 3'b000);
                            w_enable_mult_d = 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    w_cnt_d   = '0;
                    w_state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (mult_finish) begin
                        w_enable_mult_d = 1'b0;
                        w_hi_d          = mult_o;
                        if (r_funct3_q[1]) begin
                            w_state_d = S_CORR;
                        end else begin
                            w_state_d     = S_DONE;
                            w_res_valid_d = 1'b1;
                            w_res_err_d   = 1'b0;
                            w_res_data_d  = mult_o;
                            w_res_rd_d    = r_rd_q;
                        end
                    end else begin
                        w_cnt_d = w_cnt_inc;
                        if (w_cnt_inc == c_WAIT_MAX) begin
                            w_enable_mult_d = 1'b0;
                            w_state_d       = S_DONE;
                            w_res_valid_d   = 1'b1;
                            w_res_err_d     = 1'b1;
                            w_res_data_d    = '0;
                            w_res_rd_d      = r_rd_q;
                        end
                    end
                end
                S_CORR: begin
                    w_state_d     = S_DONE;
                    w_res_valid_d = 1'b1;
                    w_res_err_d   = 1'b0;
                    w_res_data_d  = r_hi_q + w_corr_a + w_corr_b;
                    w_res_rd_d    = r_rd_q;
                end
                S_DONE: begin
                    if (res_ready) begin
                        w_state_d     = S_IDLE;
                        w_res_valid_d = 1'b0;
                        w_req_ready_d = 1'b1;
                    end
                end
                default: begin
                    w_state_d       = S_IDLE;
                    w_enable_mult_d = 1'b0;
                    w_res_valid_d   = 1'b0;
                    w_req_ready_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q       <= S_IDLE;
            r_a_q           <= '0;
            r_b_q           <= '0;
            r_funct3_q      <= '0;
            r_rd_q          <= '0;
            r_cnt_q         <= '0;
            r_hi_q          <= '0;
            r_oper_a_q      <= '0;
            r_oper_b_q      <= '0;
            r_enable_mult_q <= 1'b0;
            r_operation_q   <= 1'b0;
            r_req_ready_q   <= 1'b1;
            r_res_valid_q   <= 1'b0;
            r_res_data_q    <= '0;
            r_res_rd_q      <= '0;
            r_res_err_q     <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_a_q           <= w_a_d;
            r_b_q           <= w_b_d;
            r_funct3_q      <= w_funct3_d;
            r_rd_q          <= w_rd_d;
            r_cnt_q         <= w_cnt_d;
            r_hi_q          <= w_hi_d;
            r_oper_a_q      <= w_oper_a_d;
            r_oper_b_q      <= w_oper_b_d;
            r_enable_mult_q <= w_enable_mult_d;
            r_operation_q   <= w_operation_d;
            r_req_ready_q   <= w_req_ready_d;
            r_res_valid_q   <= w_res_valid_d;
            r_res_data_q    <= w_res_data_d;
            r_res_rd_q      <= w_res_rd_d;
            r_res_err_q     <= w_res_err_d;
        end
    end

    assign req_ready   = r_req_ready_q;
    assign oper_a      = r_oper_a_q;
    assign oper_b      = r_oper_b_q;
    assign enable_mult = r_enable_mult_q;
    assign operation   = r_operation_q;
    assign res_valid   = r_res_valid_q;
    assign res_data    = r_res_data_q;
    assign res_rd      = r_res_rd_q;
    assign res_err     = r_res_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_issue_ctrl.sv
// ============================================================================
//  Module   : tb_mult_issue_ctrl
//  Purpose  : Directed self-checking bench for mult_issue_ctrl; the bench
//             plays the multiplier by driving mult_o/mult_finish by hand.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        flush;
    logic [31:0] oper_a;
    logic [31:0] oper_b;
    logic        enable_mult;
    logic        operation;
    logic [31:0] mult_o;
    logic        mult_finish;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        res_err;

    int tests_run = 0;
    int tests_failed = 0;

    mult_issue_ctrl #(.LENGTH(32), .WAIT_MAX(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct3  (req_funct3),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_rd      (req_rd),
        .flush       (flush),
        .oper_a      (oper_a),
        .oper_b      (oper_b),
        .enable_mult (enable_mult),
        .operation   (operation),
        .mult_o      (mult_o),
        .mult_finish (mult_finish),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .res_err     (res_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        req_rd     = rd;
        tick();
        req_valid  = 1'b0;
    endtask

    logic [31:0] held_data;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_rs1 = '0; req_rs2 = '0;
        req_rd = '0; flush = 1'b0; mult_o = '0; mult_finish = 1'b0; res_ready = 1'b0;
        tick();
        tick();
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_enable", {31'b0, enable_mult}, 32'd0);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_oper_a", oper_a, 32'd0);
        rst = 1'b0;
        tick();

        // MUL 7 * -3
        request(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        check("mul_issue_ready", {31'b0, req_ready}, 32'd0);
        check("mul_issue_en", {31'b0, enable_mult}, 32'd1);
        check("mul_issue_op", {31'b0, operation}, 32'd0);
        check("mul_oper_a", oper_a, 32'd7);
        check("mul_oper_b", oper_b, 32'hFFFF_FFFD);
        check("mul_issue_valid", {31'b0, res_valid}, 32'd0);
        tick();
        check("mul_wait_en", {31'b0, enable_mult}, 32'd1);
        check("mul_wait_valid", {31'b0, res_valid}, 32'd0);
        mult_finish = 1'b1; mult_o = 32'hFFFF_FFEB;
        tick();
        mult_finish = 1'b0;
        check("mul_valid_at3", {31'b0, res_valid}, 32'd1);
        check("mul_data", res_data, 32'hFFFF_FFEB);
        check("mul_err", {31'b0, res_err}, 32'd0);
        check("mul_rd", {27'b0, res_rd}, 32'd5);
        check("mul_en_off", {31'b0, enable_mult}, 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("mul_idle_ready", {31'b0, req_ready}, 32'd1);
        check("mul_idle_valid", {31'b0, res_valid}, 32'd0);

        // MULH 0x80000000^2
        request(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd9);
        check("mulh_issue_op", {31'b0, operation}, 32'd1);
        tick();
        check("mulh_wait_op", {31'b0, operation}, 32'd1);
        mult_finish = 1'b1; mult_o = 32'h4000_0000;
        tick();
        mult_finish = 1'b0;
        check("mulh_valid", {31'b0, res_valid}, 32'd1);
        check("mulh_data", res_data, 32'h4000_0000);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // MULHU 0xFFFFFFFF^2 with backpressure
        request(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17);
        tick();
        mult_finish = 1'b1; mult_o = 32'h0000_0000;
        tick();
        mult_finish = 1'b0;
        check("mulhu_corr_valid", {31'b0, res_valid}, 32'd0);
        check("mulhu_corr_en", {31'b0, enable_mult}, 32'd0);
        tick();
        check("mulhu_valid_at4", {31'b0, res_valid}, 32'd1);
        check("mulhu_data", res_data, 32'hFFFF_FFFE);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'b0, res_valid}, 32'd1);
            check("bp_data", res_data, 32'hFFFF_FFFE);
            check("bp_rd", {27'b0, res_rd}, 32'd17);
            check("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_idle_ready", {31'b0, req_ready}, 32'd1);
        check("bp_idle_valid", {31'b0, res_valid}, 32'd0);

        // MULHSU 0xFFFFFFFF * 2
        request(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3);
        tick();
        mult_finish = 1'b1; mult_o = 32'hFFFF_FFFF;
        tick();
        mult_finish = 1'b0;
        tick();
        check("mulhsu_valid", {31'b0, res_valid}, 32'd1);
        check("mulhsu_data", res_data, 32'hFFFF_FFFF);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Timeout: finish never comes
        request(3'b000, 32'd3, 32'd4, 5'd21);
        tick();
        for (int i = 0; i < 14; i++) tick();
        check("to_wait14_valid", {31'b0, res_valid}, 32'd0);
        check("to_wait14_en", {31'b0, enable_mult}, 32'd1);
        tick();
        check("to_valid", {31'b0, res_valid}, 32'd1);
        check("to_err", {31'b0, res_err}, 32'd1);
        check("to_data", res_data, 32'd0);
        check("to_rd", {27'b0, res_rd}, 32'd21);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Illegal funct3 after a result with nonzero data
        request(3'b100, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8);
        check("ill_valid", {31'b0, res_valid}, 32'd1);
        check("ill_err", {31'b0, res_err}, 32'd1);
        check("ill_data", res_data, 32'd0);
        check("ill_en", {31'b0, enable_mult}, 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("ill_idle_ready", {31'b0, req_ready}, 32'd1);

        // Flush during WAIT
        request(3'b000, 32'd2, 32'd3, 5'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_en", {31'b0, enable_mult}, 32'd0);
        check("fl_valid", {31'b0, res_valid}, 32'd0);
        check("fl_ready", {31'b0, req_ready}, 32'd1);
        mult_finish = 1'b1; mult_o = 32'd6;
        tick();
        mult_finish = 1'b0;
        check("fl_stray_finish", {31'b0, res_valid}, 32'd0);

        // Flush together with a request in IDLE: not accepted
        req_valid = 1'b1; req_funct3 = 3'b000; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        check("fl_idle_ready", {31'b0, req_ready}, 32'd1);
        check("fl_idle_en", {31'b0, enable_mult}, 32'd0);

        // Async reset during CORR
        request(3'b011, 32'hFFFF_FFFF, 32'd5, 5'd2);
        tick();
        mult_finish = 1'b1; mult_o = 32'd1;
        tick();
        mult_finish = 1'b0;
        held_data = res_data;
        #1 rst = 1'b1;
        #1;
        check("rst_corr_en", {31'b0, enable_mult}, 32'd0);
        check("rst_corr_valid", {31'b0, res_valid}, 32'd0);
        check("rst_corr_ready", {31'b0, req_ready}, 32'd1);
        #1 rst = 1'b0;
        tick();
        tick();
        check("rst_corr_no_result", {31'b0, res_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
- Sequential issue/retire controller sitting directly upstream of the radix-8 Booth multiplier (mult_radix8_top).
- Accepts RV32M multiply requests (MUL/MULH/MULHSU/MULHU) from the execute stage and drives the multiplier's operand/enable/operation inputs.
- Waits for mult_finish, applies the unsigned high-word correction the signed-only Booth array needs, and returns the result with valid/ready handshakes.

Parameters:
- length, 32, operand/result width.
- WAIT_MAX, 15, maximum cycles in WAIT before declaring timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx is illegal.
- req_rs1  in  length  operand a.
- req_rs2  in  length  operand b.
- req_rd  in  5  destination register tag.
- flush  in  1  pipeline kill.
- oper_a  out  length  to multiplier.
- oper_b  out  length  to multiplier.
- enable_mult  out  1  to multiplier.
- operation  out  1  to multiplier: 0 low word, 1 high word.
- mult_o  in  length  multiplier result.
- mult_finish  in  1  multiplier done.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  length  final result.
- res_rd  out  5  tag echoed from request.
- res_err  out  1  timeout or illegal funct3; qualified by res_valid.

Behaviour:
- Reset values: all outputs 0, except req_ready=1; state=IDLE; wait counter=0.
- States: IDLE, ISSUE, WAIT, CORR, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch rs1, rs2, funct3, rd.
  - funct3[2]=1 goes straight to DONE with res_err=1 and res_data=0.
  - Otherwise go to ISSUE.
- ISSUE:
  - Drive oper_a/oper_b from the latched operands.
  - operation = (funct3!=000).
  - enable_mult=1; clear counter; go to WAIT.
- WAIT:
  - enable_mult stays 1; operands are held stable.
  - On mult_finish, capture mult_o and deassert enable_mult the next cycle.
  - Then go to CORR if funct3 is 010 or 011; otherwise go to DONE.
  - Counter increments each WAIT cycle. If it reaches WAIT_MAX without mult_finish, go to DONE with res_err=1 and res_data=0.
- CORR (one cycle), correction mod 2^length:
  - MULHU: res = hi + (a[31]?b:0) + (b[31]?a:0).
  - MULHSU: res = hi + (b[31]?a:0).
- DONE:
  - res_valid=1; res_data, res_rd and res_err are held stable until res_ready.
  - When res_valid & res_ready, go to IDLE; req_ready rises the next cycle. There is no same-cycle re-accept.
- req_ready=0 in every state except IDLE.
- Minimum latency, request accept to res_valid: 3 cycles for MUL/MULH, 4 for MULHSU/MULHU (mult_finish assumed in the first WAIT cycle).
- flush:
  - In any state, flush returns to IDLE next cycle, drops the result, and deasserts enable_mult and res_valid.
  - flush with req_valid in IDLE: the request is not accepted.
  - flush has priority over res_ready.
- mult_finish outside WAIT is ignored.
- rst mid-operation: all state is cleared immediately (asynchronously). No result is produced.

Test Plan:
- MUL: rs1=7, rs2=0xFFFFFFFD, mult_finish in the first WAIT cycle -> res_data=0xFFFFFFEB, res_err=0, res_valid 3 cycles after accept.
- MULH: 0x80000000 × 0x80000000 -> res_data=0x40000000, operation=1 during ISSUE/WAIT.
- MULHU: 0xFFFFFFFF × 0xFFFFFFFF, mult_o=0x00000000 -> res_data=0xFFFFFFFE after the CORR cycle. MULHSU: 0xFFFFFFFF × 0x00000002, mult_o=0xFFFFFFFF -> res_data=0xFFFFFFFF.
- Backpressure: res_ready held low 5 cycles -> res_valid/res_data/res_rd stable, req_ready=0 throughout; IDLE entered one cycle after res_ready.
- Timeout: mult_finish never asserted -> after WAIT_MAX=15 WAIT cycles, res_valid=1, res_err=1, res_data=0. Illegal funct3=100 -> res_err=1 without enable_mult ever asserting.
- flush asserted during WAIT, and separately rst asserted during CORR -> enable_mult=0 and res_valid=0 next cycle (immediately for rst), req_ready=1, no result delivered.
